// File: rtl/common.sv
// Shared data-bus types used between the memory stage and its responder.
// Also holds the responder's FSM state encoding.
package common;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dresp_state_t;

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, seed 8'hA5.
// Drives the responder's optional latency jitter.
module lfsr8 (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] out
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out <= 8'hA5;
        end else begin
            out <= {out[6:0], out[7] ^ out[5] ^ out[4] ^ out[3]};
        end
    end

endmodule

// File: rtl/dbus_responder.sv
// Data-bus responder: byte-writable word memory behind the core's data bus
// with programmable, optionally jittered, response latency.
module dbus_responder
    import common::*;
#(
    parameter int          DEPTH   = 1024,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int          LATENCY = 2,
    parameter int          JITTER  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  dbus_req_t   dreq,
    output dbus_resp_t  dresp,
    output logic [31:0] n_rd,
    output logic [31:0] n_wr
);

    localparam int AW = $clog2(DEPTH);

    dresp_state_t state;
    logic [31:0]  cnt;
    logic [63:0]  r_addr;
    logic [7:0]   r_strb;
    logic [63:0]  r_data;
    logic         data_ok;
    logic [63:0]  rdata;
    logic [7:0]   rnd;
    logic [63:0]  mem [DEPTH];

    logic [63:0]  a;
    logic [63:0]  off;
    logic         hit;
    logic [AW-1:0] idx;
    logic [63:0]  rd_word;
    logic [31:0]  load;
    logic         unused_bits;

    lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .out   (rnd)
    );

    // In IDLE the live request is decoded so a zero-wait load can respond at once.
    assign a       = (state == IDLE) ? dreq.addr : r_addr;
    assign off     = a - BASE;
    assign hit     = (a >= BASE) && (off[63:3] < 61'(DEPTH));
    assign idx     = off[AW+2:3];
    assign rd_word = hit ? mem[idx] : 64'h0;
    assign load    = 32'(LATENCY - 1)
                   + ((JITTER != 0) ? {30'd0, rnd[1:0]} : 32'd0);

    assign unused_bits = ^{dreq.size, off[2:0], rnd[7:2]};

    always_comb begin
        dresp         = '0;
        dresp.addr_ok = reset && (state == IDLE) && dreq.valid;
        dresp.data_ok = data_ok;
        dresp.data    = rdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            r_addr  <= '0;
            r_strb  <= '0;
            r_data  <= '0;
            data_ok <= 1'b0;
            rdata   <= '0;
            n_rd    <= '0;
            n_wr    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (dreq.valid) begin
                        r_addr <= dreq.addr;
                        r_strb <= dreq.strobe;
                        r_data <= dreq.data;
                        cnt    <= load;
                        if (load == 32'd0) begin
                            state   <= RESP;
                            data_ok <= 1'b1;
                            rdata   <= rd_word;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 32'd1;
                    if (cnt == 32'd1) begin
                        state   <= RESP;
                        data_ok <= 1'b1;
                        rdata   <= rd_word;
                    end
                end
                RESP: begin
                    data_ok <= 1'b0;
                    state   <= IDLE;
                    if (r_strb == 8'h00) begin
                        n_rd <= n_rd + 32'd1;
                    end else begin
                        n_wr <= n_wr + 32'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    data_ok <= 1'b0;
                end
            endcase
        end
    end

    // Write lands on the RESP edge so the response carries the pre-write word.
    always_ff @(posedge clk) begin
        if (state == RESP && hit) begin
            for (int i = 0; i < 8; i++) begin
                if (r_strb[i]) begin
                    mem[idx][8*i +: 8] <= r_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder: three instances cover LATENCY=2,
// LATENCY=1 back-to-back, and LATENCY=2 with jitter.
module tb_dbus_responder;
    import common::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dbus_req_t   rq  [3];
    dbus_resp_t  rs  [3];
    logic [31:0] nrd [3];
    logic [31:0] nwr [3];

    int ncmp  = 0;
    int nfail = 0;

    dbus_responder #(.LATENCY(2), .JITTER(0)) u0 (
        .clk(clk), .reset(reset), .dreq(rq[0]), .dresp(rs[0]),
        .n_rd(nrd[0]), .n_wr(nwr[0]));
    dbus_responder #(.LATENCY(1), .JITTER(0)) u1 (
        .clk(clk), .reset(reset), .dreq(rq[1]), .dresp(rs[1]),
        .n_rd(nrd[1]), .n_wr(nwr[1]));
    dbus_responder #(.LATENCY(2), .JITTER(1)) u2 (
        .clk(clk), .reset(reset), .dreq(rq[2]), .dresp(rs[2]),
        .n_rd(nrd[2]), .n_wr(nwr[2]));

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full request: drive at a negedge, hold until data_ok, then drop.
    task automatic req(input int k, input logic [63:0] addr,
                       input logic [7:0] strb, input logic [63:0] wd,
                       output logic [63:0] got, output int lat);
        bit done;
        done = 1'b0;
        got  = '0;
        lat  = 0;
        @(negedge clk);
        rq[k].valid  = 1'b1;
        rq[k].addr   = addr;
        rq[k].strobe = strb;
        rq[k].data   = wd;
        rq[k].size   = MSIZE8;
        #1 chk("addr_ok_idle", 64'(rs[k].addr_ok), 64'd1);
        for (int c = 1; c <= 20 && !done; c++) begin
            @(negedge clk);
            #1;
            chk("addr_ok_busy", 64'(rs[k].addr_ok), 64'd0);
            if (rs[k].data_ok) begin
                got  = rs[k].data;
                lat  = c;
                done = 1'b1;
                rq[k].valid = 1'b0;
            end
        end
        if (!done) chk("timeout", 64'(done), 64'd1);
    endtask

    function automatic logic [63:0] pat(input int i);
        logic [31:0] h;
        h = 32'hC0DE_0000 + 32'(i);
        return {h, ~h};
    endfunction

    logic [63:0] g;
    int          l;
    logic        ao  [4];
    logic        dok [4];
    logic [63:0] dat [4];
    int          w;
    int          lmin;
    int          lmax;

    initial begin
        for (int k = 0; k < 3; k++) rq[k] = '0;
        reset = 1'b0;
        rq[0].valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_addr_ok", 64'(rs[0].addr_ok), 64'd0);
        chk("rst_data_ok", 64'(rs[0].data_ok), 64'd0);
        chk("rst_data", rs[0].data, 64'h0);
        chk("rst_n_rd", 64'(nrd[0]), 64'd0);
        chk("rst_n_wr", 64'(nwr[0]), 64'd0);
        rq[0].valid = 1'b0;
        reset = 1'b1;

        req(0, 64'h8000_0018, 8'hFF, 64'hDEAD_BEEF_0123_4567, g, l);
        chk("wr_lat", 64'(l), 64'd2);
        req(0, 64'h8000_0018, 8'h00, 64'h0, g, l);
        chk("rd_data", g, 64'hDEAD_BEEF_0123_4567);
        chk("rd_lat", 64'(l), 64'd2);
        @(negedge clk);
        #1;
        chk("rd_ok_once", 64'(rs[0].data_ok), 64'd0);
        chk("n_rd_1", 64'(nrd[0]), 64'd1);
        chk("n_wr_1", 64'(nwr[0]), 64'd1);

        req(0, 64'h8000_0018, 8'h0F, 64'h1111_2222_3333_4444, g, l);
        chk("wr_prewrite", g, 64'hDEAD_BEEF_0123_4567);
        req(0, 64'h8000_001C, 8'h00, 64'h0, g, l);
        chk("partial_rd", g, 64'hDEAD_BEEF_3333_4444);
        req(0, 64'h7FFF_FFF8, 8'h00, 64'h0, g, l);
        chk("oor_low_rd", g, 64'h0);
        req(0, 64'h8000_0000, 8'hFF, 64'h0A0A_0A0A_0B0B_0B0B, g, l);
        req(0, 64'h8000_2000, 8'hFF, 64'h5555_5555_5555_5555, g, l);
        chk("oor_high_wr", g, 64'h0);
        req(0, 64'h8000_0000, 8'h00, 64'h0, g, l);
        chk("no_alias", g, 64'h0A0A_0A0A_0B0B_0B0B);
        req(0, 64'h8000_1FF8, 8'hFF, 64'hCAFE_F00D_1234_5678, g, l);
        req(0, 64'h8000_1FF8, 8'h00, 64'h0, g, l);
        chk("top_word", g, 64'hCAFE_F00D_1234_5678);
        @(negedge clk);
        chk("n_rd_5", 64'(nrd[0]), 64'd5);
        chk("n_wr_5", 64'(nwr[0]), 64'd5);

        req(1, 64'h8000_0040, 8'hFF, 64'h1111_1111_1111_1111, g, l);
        chk("l1_lat", 64'(l), 64'd1);
        req(1, 64'h8000_0048, 8'hFF, 64'h2222_2222_2222_2222, g, l);
        @(negedge clk);
        rq[1].valid  = 1'b1;
        rq[1].addr   = 64'h8000_0040;
        rq[1].strobe = 8'h00;
        for (int i = 0; i < 4; i++) begin
            #1;
            ao[i]  = rs[1].addr_ok;
            dok[i] = rs[1].data_ok;
            dat[i] = rs[1].data;
            if (i == 1) rq[1].addr = 64'h8000_0048;
            if (i == 3) rq[1].valid = 1'b0;
            @(negedge clk);
        end
        chk("held_addr_ok", 64'({ao[0], ao[1], ao[2], ao[3]}), 64'b1010);
        chk("held_data_ok", 64'({dok[0], dok[1], dok[2], dok[3]}), 64'b0101);
        chk("held_d0", dat[1], 64'h1111_1111_1111_1111);
        chk("held_d1", dat[3], 64'h2222_2222_2222_2222);
        #1;
        chk("held_after", 64'(rs[1].data_ok), 64'd0);
        chk("held_n_rd", 64'(nrd[1]), 64'd2);

        @(negedge clk);
        rq[0].valid  = 1'b1;
        rq[0].addr   = 64'h8000_0018;
        rq[0].strobe = 8'hFF;
        rq[0].data   = 64'h9999_9999_9999_9999;
        @(negedge clk);
        #1;
        reset = 1'b0;
        rq[0].valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstw_data_ok", 64'(rs[0].data_ok), 64'd0);
        chk("rstw_n_wr", 64'(nwr[0]), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rstw_no_resp", 64'(rs[0].data_ok), 64'd0);
        req(0, 64'h8000_0018, 8'h00, 64'h0, g, l);
        chk("rstw_unchanged", g, 64'hDEAD_BEEF_3333_4444);
        @(negedge clk);
        chk("rstw_n_rd", 64'(nrd[0]), 64'd1);
        chk("rstw_n_wr2", 64'(nwr[0]), 64'd0);

        for (int i = 0; i < 8; i++) begin
            req(2, 64'h8000_0000 + 64'(i * 8), 8'hFF, pat(i), g, l);
        end
        lmin = 100;
        lmax = 0;
        for (int n = 0; n < 100; n++) begin
            w = int'($urandom_range(0, 7));
            req(2, 64'h8000_0000 + 64'(w * 8), 8'h00, 64'h0, g, l);
            chk("jit_data", g, pat(w));
            chk("jit_lat", 64'(l >= 2 && l <= 5), 64'd1);
            if (l < lmin) lmin = l;
            if (l > lmax) lmax = l;
        end
        @(negedge clk);
        chk("jit_n_rd", 64'(nrd[2]), 64'd100);
        chk("jit_n_wr", 64'(nwr[2]), 64'd8);
        chk("jit_spread", 64'(lmax > lmin), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
